// File: rtl/hazard_pkg.sv
// Shared types and constants for the issue hazard scheduler.
// Scoreboard entry layout and pipeline stage indices.
package hazard_pkg;
  localparam logic [4:0] XZR = 5'd31;

  localparam int RFREAD  = 0;
  localparam int ALU     = 1;
  localparam int DATAMEM = 2;
  localparam int RFWRITE = 3;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       flagset;
  } sb_entry_t;
endpackage

// File: rtl/hazard_scheduler_sb_match.sv
// Compares one decoder source register against in-flight writers.
// Entries beyond i_last are ignored (write-first regfile bypass).
module sb_match
  import hazard_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int LW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic [4:0]            i_src,
  input  logic                  i_used,
  input  sb_entry_t [STAGES-1:0] i_sb,
  input  logic [LW-1:0]         i_last,
  output logic                  o_hit
);
  logic w_any;

  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (i <= int'(i_last) &&
          i_sb[i].valid &&
          i_sb[i].regwrite &&
          i_sb[i].rd == i_src)
        w_any = 1'b1;
    end
  end

  assign o_hit = w_any & i_used & (i_src != XZR);
endmodule

// File: rtl/hazard_scheduler.sv
// Issue controller: stalls decode on register, flag and branch hazards.
// Tracks in-flight writers and counts stall cycles (saturating).
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int STAGES       = 4,
  parameter int FLAG_STAGE   = 1,
  parameter int WRITE_BYPASS = 0,
  parameter int BR_SHADOW    = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rn,
  input  logic             dec_rn_used,
  input  logic [4:0]       dec_rm,
  input  logic             dec_rm_used,
  input  logic [4:0]       dec_rd,
  input  logic             dec_regwrite,
  input  logic             dec_flagset,
  input  logic             dec_flaguse,
  input  logic             dec_branch,
  output logic             issue,
  output logic             bubble,
  output logic             stall_fetch,
  output logic [CNT_W-1:0] stall_count
);
  localparam int LW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int SW = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;
  localparam int LAST_I = (WRITE_BYPASS != 0) ? STAGES - 2 : STAGES - 1;
  localparam logic [LW-1:0] LAST = LW'(LAST_I);

  sb_entry_t [STAGES-1:0] r_sb;
  logic [SW-1:0]          r_shd;
  logic [CNT_W-1:0]       r_cnt;

  logic      w_rn_hit;
  logic      w_rm_hit;
  logic      w_flag_hit;
  logic      w_issue;
  logic      w_stall;
  sb_entry_t w_new;

  sb_match #(.STAGES(STAGES), .LW(LW)) u_rn (
    .i_src  (dec_rn),
    .i_used (dec_rn_used),
    .i_sb   (r_sb),
    .i_last (LAST),
    .o_hit  (w_rn_hit)
  );

  sb_match #(.STAGES(STAGES), .LW(LW)) u_rm (
    .i_src  (dec_rm),
    .i_used (dec_rm_used),
    .i_sb   (r_sb),
    .i_last (LAST),
    .o_hit  (w_rm_hit)
  );

  always_comb begin
    w_flag_hit = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (i <= FLAG_STAGE && r_sb[i].valid && r_sb[i].flagset)
        w_flag_hit = 1'b1;
    end
  end

  // Reset gates issue so nothing enters while the datapath is held.
  assign w_issue = reset & dec_valid & ~w_rn_hit & ~w_rm_hit &
                   ~(dec_flaguse & w_flag_hit) & (r_shd == '0);
  assign w_stall = dec_valid & ~w_issue;

  always_comb begin
    w_new          = '0;
    w_new.valid    = 1'b1;
    w_new.rd       = dec_rd;
    w_new.regwrite = dec_regwrite & (dec_rd != XZR);
    w_new.flagset  = dec_flagset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sb  <= '0;
      r_shd <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = STAGES - 1; i > 0; i--)
        r_sb[i] <= r_sb[i-1];
      r_sb[0] <= w_issue ? w_new : '0;
      if (w_issue && dec_branch)
        r_shd <= SW'(BR_SHADOW);
      else if (r_shd != '0)
        r_shd <= r_shd - 1'b1;
      if (w_stall && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign issue       = w_issue;
  assign stall_fetch = w_stall;
  assign bubble      = w_stall;
  assign stall_count = r_cnt;
endmodule
